// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and constants for the SoC UART receive/transmit paths
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 4;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : show-ahead FIFO, power-of-2 depth, push+pop allowed when full
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               pop,
    output logic [DATA_W-1:0]  data_out,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == LEVEL_W'(DEPTH));
    assign level    = r_count;
    assign data_out = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LEVEL_W'(1);
                2'b01:   r_count <= r_count - LEVEL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver : 8N1 UART receiver with mid-bit sampling, error flags and FIFO
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rx,
    input  logic [15:0]        clk_div,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clear
);

    logic                      r_sync1;
    logic                      r_rx_s;
    uart_rx_state_t            r_state;
    uart_rx_state_t            w_next_state;
    logic [15:0]               r_cnt;
    logic [15:0]               r_div_q;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_cnt_zero;
    logic [15:0]               w_half_load;
    logic [15:0]               w_full_load;
    logic                      w_start_det;
    logic                      w_load_full;
    logic                      w_shift;
    logic                      w_push;
    logic                      w_set_ferr;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      w_pop;

    // Flops reset to the idle level so reset release cannot look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_cnt_zero  = (r_cnt == 16'd0);
    assign w_half_load = (clk_div >> 1) - 16'd1;
    assign w_full_load = r_div_q - 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE:  if (!r_rx_s) w_next_state = RX_START;
            RX_START: if (w_cnt_zero) w_next_state = r_rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_next_state = RX_STOP;
            RX_STOP:  if (w_cnt_zero) w_next_state = r_rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (r_rx_s) w_next_state = RX_IDLE;
            default:  w_next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        w_start_det = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_set_ferr  = 1'b0;
        case (r_state)
            RX_IDLE:  w_start_det = !r_rx_s;
            RX_START: w_load_full = w_cnt_zero && !r_rx_s;
            RX_DATA: begin
                w_shift     = w_cnt_zero;
                w_load_full = w_cnt_zero;
            end
            RX_STOP: begin
                w_push     = w_cnt_zero && r_rx_s;
                w_set_ferr = w_cnt_zero && !r_rx_s;
            end
            default: ;
        endcase
    end

    // The divider is captured only at the start edge, so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div_q   <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            if (w_start_det) begin
                r_div_q <= clk_div;
                r_cnt   <= w_half_load;
            end else if (w_load_full) begin
                r_cnt <= w_full_load;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 16'd1;
            end

            if ((r_state == RX_START) && w_load_full) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift) begin
                r_shreg <= {r_rx_s, r_shreg[UART_DATA_BITS-1:1]};
            end
        end
    end

    assign w_pop = rx_ready && !w_fifo_empty;

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_set_ferr | (r_frame_err & ~err_clear);
            r_overrun   <= (w_push & w_fifo_full & ~w_pop) | (r_overrun & ~err_clear);
        end
    end

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .DATA_W  (UART_DATA_BITS),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .data_in  (r_shreg),
        .pop      (rx_ready),
        .data_out (rx_data),
        .empty    (w_fifo_empty),
        .full     (w_fifo_full),
        .level    (level)
    );

    assign rx_valid  = !w_fifo_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire
